// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Holds the response owner encoding and the byte-to-word index helper.
package imem_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_AW     = 18;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   misalign;
  } resp_t;

  // Upper address bits are dropped, so addresses alias across the array.
  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[MEM_AW+1:2];
  endfunction

endpackage

// File: rtl/imem_arb_prio.sv
// Loader-over-fetch priority arbiter with a starvation counter that forces
// a fetch grant after MAX_BURST consecutive loader wins against a waiting fetch.
module imem_arb_prio #(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic l_req,
  output logic f_gnt,
  output logic l_gnt
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] burst_cnt;
  logic          burst_full;

  assign burst_full = (burst_cnt == CW'(MAX_BURST));

  always_comb begin
    f_gnt = f_req && (!l_req || burst_full);
    l_gnt = l_req && !f_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      burst_cnt <= '0;
    else if (!f_req || f_gnt)
      burst_cnt <= '0;
    else if (l_gnt && !burst_full)
      burst_cnt <= burst_cnt + 1'b1;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port IMEM arbiter: read-only fetch and read/write loader share one
// synchronous-read memory port; responses return exactly one cycle after grant.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = imem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = imem_pkg::DATA_WIDTH,
  parameter int MEM_AW     = imem_pkg::MEM_AW,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_misalign,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [MEM_AW-1:0]     m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  resp_t resp_d, resp_q;
  logic  f_mis;

  assign f_mis = (f_addr[1:0] != 2'b00);

  imem_arb_prio #(.MAX_BURST(MAX_BURST)) u_prio (
    .clk   (clk),
    .rst   (rst),
    .f_req (f_req),
    .l_req (l_req),
    .f_gnt (f_gnt),
    .l_gnt (l_gnt)
  );

  // A misaligned fetch still wins arbitration but leaves the memory idle.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    resp_d  = '{owner: OWN_NONE, misalign: 1'b0};
    if (f_gnt) begin
      resp_d = '{owner: OWN_FETCH, misalign: f_mis};
      if (!f_mis) begin
        m_en   = 1'b1;
        m_addr = word_idx(f_addr);
      end
    end else if (l_gnt) begin
      m_en   = 1'b1;
      m_we   = l_we;
      m_addr = word_idx(l_addr);
      if (l_we)
        m_wdata = l_wdata;
      else
        resp_d.owner = OWN_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      resp_q <= '{owner: OWN_NONE, misalign: 1'b0};
    else
      resp_q <= resp_d;
  end

  // Responses are suppressed while reset is asserted so a pending one is dropped at once.
  always_comb begin
    f_rvalid   = !rst && (resp_q.owner == OWN_FETCH);
    l_rvalid   = !rst && (resp_q.owner == OWN_LOAD);
    f_misalign = f_rvalid && resp_q.misalign;
    f_rdata    = (f_rvalid && !resp_q.misalign) ? m_rdata : '0;
    l_rdata    = l_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model with a shadow memory.
module tb_imem_arbiter;

  localparam int AW = 32, DW = 32, MAW = 18, MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, f_gnt, f_rvalid, f_misalign;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          l_req, l_we, l_gnt, l_rvalid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          m_en, m_we;
  logic [MAW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_misalign(f_misalign),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Synchronous-read memory, 1024 words, aliased on the low word-address bits.
  logic [DW-1:0] tmem [1024];
  logic [1023:0] tvalid;
  logic [DW-1:0] rd_q;
  logic          mem_clr;

  function automatic logic [DW-1:0] init_word(input logic [9:0] i);
    return ({22'b0, i} * 32'h9E3779B9) ^ 32'h0BADF00D;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) tvalid <= '0;
    else if (m_en) begin
      if (m_we) begin
        tmem[m_addr[9:0]]   <= m_wdata;
        tvalid[m_addr[9:0]] <= 1'b1;
      end else
        rd_q <= tvalid[m_addr[9:0]] ? tmem[m_addr[9:0]] : init_word(m_addr[9:0]);
    end
  end
  assign m_rdata = rd_q;

  // Reference view of memory contents, updated from expected write grants.
  logic [DW-1:0] sh [1024];
  logic [1023:0] shv;

  function automatic logic [DW-1:0] sh_rd(input logic [9:0] i);
    return shv[i] ? sh[i] : init_word(i);
  endfunction

  task automatic sh_wr(input logic [9:0] i, input logic [DW-1:0] d);
    sh[i] = d;
    shv[i] = 1'b1;
  endtask

  task automatic idle();
    f_req = 0; f_addr = '0; l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({f_gnt, l_gnt, f_rvalid, l_rvalid, f_misalign, m_en, m_we} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {f_gnt, l_gnt, f_rvalid, l_rvalid, f_misalign, m_en, m_we});
    end
    checks++;
    if (f_rdata !== '0 || l_rdata !== '0 || m_addr !== '0 || m_wdata !== '0) begin
      failures++; $display("FAIL reset_data f_rdata=%h l_rdata=%h m_addr=%h m_wdata=%h exp=0", f_rdata, l_rdata, m_addr, m_wdata);
    end
    @(negedge clk); rst = 0; #1;
    checks++;
    if ({f_rvalid, l_rvalid, f_gnt, l_gnt} !== 4'b0) begin
      failures++; $display("FAIL reset_release got=%b exp=0000", {f_rvalid, l_rvalid, f_gnt, l_gnt});
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk); idle(); l_req = 1; l_we = 1; l_addr = 32'h100; l_wdata = 32'h00500093; #1;
    sh_wr(10'h40, 32'h00500093);
    @(negedge clk); idle(); f_req = 1; f_addr = 32'h100; #1;
    checks++;
    if (f_gnt !== 1 || l_gnt !== 0 || m_en !== 1 || m_we !== 0 || m_addr !== 18'h40) begin
      failures++; $display("FAIL fetch_grant f_gnt=%b l_gnt=%b m_en=%b m_we=%b m_addr=%h exp 1 0 1 0 40", f_gnt, l_gnt, m_en, m_we, m_addr);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (f_rvalid !== 1 || f_rdata !== 32'h00500093 || f_misalign !== 0) begin
      failures++; $display("FAIL fetch_resp rvalid=%b rdata=%h mis=%b exp 1 00500093 0", f_rvalid, f_rdata, f_misalign);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk); idle(); f_req = 1; f_addr = 32'h102; #1;
    checks++;
    if (f_gnt !== 1 || m_en !== 0) begin
      failures++; $display("FAIL misalign_grant f_gnt=%b m_en=%b exp 1 0", f_gnt, m_en);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (f_rvalid !== 1 || f_misalign !== 1 || f_rdata !== '0) begin
      failures++; $display("FAIL misalign_resp rvalid=%b mis=%b rdata=%h exp 1 1 0", f_rvalid, f_misalign, f_rdata);
    end
  endtask

  task automatic test_write_then_fetch();
    @(negedge clk); idle(); l_req = 1; l_we = 1; l_addr = 32'h8; l_wdata = 32'hDEADBEEF; #1;
    checks++;
    if (l_gnt !== 1 || m_en !== 1 || m_we !== 1 || m_addr !== 18'h2 || m_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL ld_write l_gnt=%b m_en=%b m_we=%b m_addr=%h m_wdata=%h exp 1 1 1 2 deadbeef", l_gnt, m_en, m_we, m_addr, m_wdata);
    end
    sh_wr(10'h2, 32'hDEADBEEF);
    @(negedge clk); idle(); f_req = 1; f_addr = 32'h8; #1;
    checks++;
    if (l_rvalid !== 0 || f_gnt !== 1) begin
      failures++; $display("FAIL ld_write_noresp l_rvalid=%b f_gnt=%b exp 0 1", l_rvalid, f_gnt);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (f_rvalid !== 1 || f_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_then_fetch rvalid=%b rdata=%h exp 1 deadbeef", f_rvalid, f_rdata);
    end
  endtask

  task automatic test_starvation();
    bit exp_f, prev_f;
    prev_f = 0;
    @(negedge clk); idle(); #1;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      f_req = 1; f_addr = 32'h103; l_req = 1; l_we = 0; l_addr = 32'h8; #1;
      exp_f = ((i % 9) == 8);
      checks++;
      if (f_gnt !== exp_f || l_gnt !== !exp_f) begin
        failures++; $display("FAIL starve_gnt cyc=%0d f_gnt=%b l_gnt=%b exp %b %b", i, f_gnt, l_gnt, exp_f, !exp_f);
      end
      if (exp_f) begin
        checks++;
        if (m_en !== 0) begin
          failures++; $display("FAIL starve_mis_mem cyc=%0d m_en=%b exp 0", i, m_en);
        end
      end
      if (i > 0) begin
        checks++;
        if (prev_f ? (f_rvalid !== 1 || f_misalign !== 1 || l_rvalid !== 0)
                   : (l_rvalid !== 1 || l_rdata !== sh_rd(10'd2) || f_rvalid !== 0)) begin
          failures++; $display("FAIL starve_resp cyc=%0d f_rv=%b mis=%b l_rv=%b l_rdata=%h exp_fetch=%b", i, f_rvalid, f_misalign, l_rvalid, l_rdata, prev_f);
        end
      end
      prev_f = exp_f;
    end
    @(negedge clk); idle(); #1;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); idle(); f_req = 1; f_addr = 32'h4; #1;
    checks++;
    if (f_gnt !== 1) begin
      failures++; $display("FAIL midrst_grant f_gnt=%b exp 1", f_gnt);
    end
    @(negedge clk); rst = 1; l_req = 1; l_we = 0; l_addr = 32'h8; #1;
    checks++;
    if (f_rvalid !== 0 || f_rdata !== '0 || l_gnt !== 1 || f_gnt !== 0) begin
      failures++; $display("FAIL midrst_in_rst f_rvalid=%b f_rdata=%h l_gnt=%b f_gnt=%b exp 0 0 1 0", f_rvalid, f_rdata, l_gnt, f_gnt);
    end
    @(negedge clk); rst = 0; #1;
    checks++;
    if (l_rvalid !== 0 || f_rvalid !== 0 || l_rdata !== '0) begin
      failures++; $display("FAIL midrst_dropped l_rvalid=%b f_rvalid=%b l_rdata=%h exp 0 0 0", l_rvalid, f_rvalid, l_rdata);
    end
    for (int j = 0; j < 9; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      checks++;
      if (f_gnt !== (j == 8) || l_gnt !== (j != 8)) begin
        failures++; $display("FAIL midrst_burst cyc=%0d f_gnt=%b l_gnt=%b exp %b %b", j, f_gnt, l_gnt, j == 8, j != 8);
      end
    end
    @(negedge clk); idle(); #1;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      if (k < 3) begin f_req = 1; f_addr = 32'(k * 4); end
      #1;
      if (k < 3) begin
        checks++;
        if (f_gnt !== 1 || m_addr !== 18'(k)) begin
          failures++; $display("FAIL b2b_grant k=%0d f_gnt=%b m_addr=%h exp 1 %h", k, f_gnt, m_addr, k);
        end
      end
      if (k > 0) begin
        checks++;
        if (f_rvalid !== 1 || f_rdata !== sh_rd(10'(k - 1))) begin
          failures++; $display("FAIL b2b_resp k=%0d rvalid=%b rdata=%h exp 1 %h", k, f_rvalid, f_rdata, sh_rd(10'(k - 1)));
        end
      end
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (f_rvalid !== 0) begin
      failures++; $display("FAIL b2b_tail rvalid=%b exp 0", f_rvalid);
    end
  endtask

  task automatic test_random();
    int lwins;
    bit efg, elg, een, ewe, newf, newl;
    bit pf, pf_mis, pl;
    logic [DW-1:0] pf_d, pl_d;
    logic [MAW-1:0] eaddr;
    lwins = 0; pf = 0; pl = 0; pf_mis = 0; pf_d = '0; pl_d = '0;
    newf = 1; newl = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      if (newf) begin
        f_req = ($urandom_range(0, 2) != 0);
        f_addr = $urandom;
        if ($urandom_range(0, 3) != 0) f_addr[1:0] = 2'b00;
      end
      if (newl) begin
        l_req = ($urandom_range(0, 3) != 0);
        l_we = $urandom_range(0, 1);
        l_addr = $urandom;
        l_wdata = $urandom;
      end
      #1;
      efg = f_req && (!l_req || lwins == MB);
      elg = l_req && !efg;
      een = (efg && f_addr[1:0] == 2'b00) || elg;
      ewe = elg && l_we;
      eaddr = efg ? f_addr[MAW+1:2] : l_addr[MAW+1:2];
      checks++;
      if (f_gnt !== efg || l_gnt !== elg || m_en !== een) begin
        failures++; $display("FAIL rnd_gnt cyc=%0d f_gnt=%b l_gnt=%b m_en=%b exp %b %b %b", c, f_gnt, l_gnt, m_en, efg, elg, een);
      end
      if (een) begin
        checks++;
        if (m_we !== ewe || m_addr !== eaddr || (ewe && m_wdata !== l_wdata)) begin
          failures++; $display("FAIL rnd_mem cyc=%0d m_we=%b m_addr=%h m_wdata=%h exp %b %h %h", c, m_we, m_addr, m_wdata, ewe, eaddr, l_wdata);
        end
      end
      checks++;
      if (f_rvalid !== (pf && !rst) || f_misalign !== (pf && !rst && pf_mis) ||
          f_rdata !== ((pf && !rst) ? pf_d : '0)) begin
        failures++; $display("FAIL rnd_fresp cyc=%0d rv=%b mis=%b rdata=%h exp %b %b %h", c, f_rvalid, f_misalign, f_rdata, pf && !rst, pf && !rst && pf_mis, (pf && !rst) ? pf_d : '0);
      end
      checks++;
      if (l_rvalid !== (pl && !rst) || l_rdata !== ((pl && !rst) ? pl_d : '0)) begin
        failures++; $display("FAIL rnd_lresp cyc=%0d rv=%b rdata=%h exp %b %h", c, l_rvalid, l_rdata, pl && !rst, (pl && !rst) ? pl_d : '0);
      end
      pf = efg && !rst;
      pf_mis = (f_addr[1:0] != 2'b00);
      pf_d = pf_mis ? '0 : sh_rd(f_addr[11:2]);
      pl = elg && !l_we && !rst;
      pl_d = sh_rd(l_addr[11:2]);
      if (ewe) sh_wr(l_addr[11:2], l_wdata);
      if (rst || !f_req || efg) lwins = 0;
      else if (elg && lwins < MB) lwins++;
      newf = !f_req || efg;
      newl = !l_req || elg;
    end
    @(negedge clk); rst = 0; idle(); #1;
  endtask

  initial begin
    shv = '0;
    rst = 1; mem_clr = 1; idle();
    repeat (2) @(negedge clk);
    mem_clr = 0;
    test_reset();
    test_single_fetch();
    test_misalign();
    test_write_then_fetch();
    test_starvation();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
